// File: rtl/frame_pkg.sv
// Shared types and defaults for the per-frame object mover.
package frame_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_MOVE
   } state_t;

   typedef enum logic [1:0] {
      MV_NONE,
      MV_LEFT,
      MV_RIGHT
   } move_t;

   localparam int POS_W_DEF   = 10;
   localparam int POS_MAX_DEF = 639;

   // Opposing buttons cancel out, so a simultaneous press reads as no motion.
   function automatic move_t decode_buttons(input logic left, input logic right);
      case ({left, right})
         2'b10:   return MV_LEFT;
         2'b01:   return MV_RIGHT;
         default: return MV_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop; emits a registered one-cycle pulse
// on each rising edge of an asynchronous level input.
module sync_rise (
   input  logic clk_in,
   input  logic reset,
   input  logic sig_in,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic hist;

   // NOTE: every flop here is sequential state, so all use non-blocking
   // assignments; blocking ones would collapse the chain into a single stage.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         hist  <= sync2;
         rise  <= sync2 & ~hist;
      end
   end

endmodule

// File: rtl/frame_step_mover.sv
// Per-frame game-state update: turns the frame square wave into a tick and
// steps a saturating 1-D position left or right once per enabled frame.
module frame_step_mover
   import frame_pkg::*;
#(
   parameter int POS_W     = POS_W_DEF,
   parameter int POS_MAX   = POS_MAX_DEF,
   parameter int STEP      = 4,
   parameter int RESET_POS = 320
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             enable,
   input  logic             btn_left,
   input  logic             btn_right,
   output logic             frame_tick,
   output logic [POS_W-1:0] pos,
   output logic             pos_valid,
   output logic             at_edge
);

   localparam logic [POS_W:0]   STEP_X      = (POS_W + 1)'(STEP);
   localparam logic [POS_W:0]   POS_MAX_X   = (POS_W + 1)'(POS_MAX);
   localparam logic [POS_W-1:0] RESET_POS_V = POS_W'(RESET_POS);
   localparam logic             RESET_EDGE  = (RESET_POS == 0) || (RESET_POS == POS_MAX);

   state_t           state, state_nxt;
   move_t            req, req_nxt;
   logic [POS_W-1:0] pos_nxt;
   logic             pos_valid_nxt;
   logic             at_edge_nxt;
   logic [POS_W:0]   pos_x;
   logic [POS_W:0]   moved_x;

   logic btn_l_s1, btn_l_s2;
   logic btn_r_s1, btn_r_s2;

   sync_rise u_tick_sync (
      .clk_in (clk_in),
      .reset  (reset),
      .sig_in (tick_in),
      .rise   (frame_tick)
   );

   // Raw buttons are only synchronized; sampling once per frame filters bounce.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         btn_l_s1 <= 1'b0;
         btn_l_s2 <= 1'b0;
         btn_r_s1 <= 1'b0;
         btn_r_s2 <= 1'b0;
      end else begin
         btn_l_s1 <= btn_left;
         btn_l_s2 <= btn_l_s1;
         btn_r_s1 <= btn_right;
         btn_r_s2 <= btn_r_s1;
      end
   end

   // One extra bit keeps pos+STEP from wrapping before the saturation compare.
   always_comb begin
      pos_x = {1'b0, pos};
      case (req)
         MV_RIGHT: moved_x = (pos_x + STEP_X > POS_MAX_X) ? POS_MAX_X : pos_x + STEP_X;
         MV_LEFT:  moved_x = (pos_x < STEP_X) ? '0 : pos_x - STEP_X;
         default:  moved_x = pos_x;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt     = state;
      req_nxt       = req;
      pos_nxt       = pos;
      pos_valid_nxt = 1'b0;
      at_edge_nxt   = at_edge;
      case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (frame_tick) begin
               req_nxt   = decode_buttons(btn_l_s2, btn_r_s2);
               state_nxt = S_MOVE;
            end
         end
         S_MOVE: begin
            pos_nxt       = moved_x[POS_W-1:0];
            pos_valid_nxt = 1'b1;
            at_edge_nxt   = (moved_x == '0) || (moved_x == POS_MAX_X);
            state_nxt     = enable ? S_WAIT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         req       <= MV_NONE;
         pos       <= RESET_POS_V;
         pos_valid <= 1'b0;
         at_edge   <= RESET_EDGE;
      end else begin
         req       <= req_nxt;
         pos       <= pos_nxt;
         pos_valid <= pos_valid_nxt;
         at_edge   <= at_edge_nxt;
      end
   end

endmodule

// File: tb/tb_frame_step_mover.sv
// Directed bench for frame_step_mover: a default instance plus one reset
// next to the left limit, sharing clock, tick, enable and reset.
module tb_frame_step_mover;
   import frame_pkg::*;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       tick_in;
   logic       enable;
   logic       btn_left, btn_right;
   logic       btn_left_e, btn_right_e;
   logic       frame_tick, pos_valid, at_edge;
   logic       frame_tick_e, pos_valid_e, at_edge_e;
   logic [9:0] pos, pos_e;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   frame_step_mover dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .tick_in    (tick_in),
      .enable     (enable),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .frame_tick (frame_tick),
      .pos        (pos),
      .pos_valid  (pos_valid),
      .at_edge    (at_edge)
   );

   frame_step_mover #(.RESET_POS(2)) dut_e (
      .clk_in     (clk_in),
      .reset      (reset),
      .tick_in    (tick_in),
      .enable     (enable),
      .btn_left   (btn_left_e),
      .btn_right  (btn_right_e),
      .frame_tick (frame_tick_e),
      .pos        (pos_e),
      .pos_valid  (pos_valid_e),
      .at_edge    (at_edge_e)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full tick_in period (20 cycles high, 20 low) with latency checks.
   task automatic frame(input string tag, input bit exp_move, input int exp_pos,
                        input int exp_pos_e, input bit drop_en);
      @(negedge clk_in);
      tick_in = 1'b1;
      repeat (2) @(negedge clk_in);
      check({tag, ".ft_early"}, 32'(frame_tick), 32'd0);
      @(negedge clk_in);
      check({tag, ".ft"}, 32'(frame_tick), 32'd1);
      check({tag, ".ft_e"}, 32'(frame_tick_e), 32'd1);
      if (drop_en) enable = 1'b0;
      @(negedge clk_in);
      check({tag, ".ft_one"}, 32'(frame_tick), 32'd0);
      check({tag, ".pv_early"}, 32'(pos_valid), 32'd0);
      @(negedge clk_in);
      check({tag, ".pv"}, 32'(pos_valid), 32'(exp_move));
      check({tag, ".pv_e"}, 32'(pos_valid_e), 32'(exp_move));
      check({tag, ".pos"}, 32'(pos), 32'(exp_pos));
      check({tag, ".pos_e"}, 32'(pos_e), 32'(exp_pos_e));
      check({tag, ".edge"}, 32'(at_edge), 32'(exp_pos == 0 || exp_pos == 639));
      check({tag, ".edge_e"}, 32'(at_edge_e), 32'(exp_pos_e == 0 || exp_pos_e == 639));
      @(negedge clk_in);
      check({tag, ".pv_one"}, 32'(pos_valid), 32'd0);
      repeat (14) @(negedge clk_in);
      tick_in = 1'b0;
      repeat (20) @(negedge clk_in);
      check({tag, ".fall_quiet"}, 32'(pos_valid), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      tick_in     = 1'b0;
      enable      = 1'b0;
      btn_left    = 1'b0;
      btn_right   = 1'b0;
      btn_left_e  = 1'b0;
      btn_right_e = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst.pos", 32'(pos), 32'd320);
      check("rst.pv", 32'(pos_valid), 32'd0);
      check("rst.ft", 32'(frame_tick), 32'd0);
      check("rst.edge", 32'(at_edge), 32'd0);
      check("rst.state", 32'(dut.state), 32'(S_IDLE));
      check("rst.pos_e", 32'(pos_e), 32'd2);
      check("rst.edge_e", 32'(at_edge_e), 32'd0);

      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk_in);
      frame("idle_btn", 1'b1, 320, 2, 1'b0);

      btn_right = 1'b1;
      frame("right1", 1'b1, 324, 2, 1'b0);
      frame("right2", 1'b1, 328, 2, 1'b0);
      frame("right3", 1'b1, 332, 2, 1'b0);

      btn_right  = 1'b0;
      btn_left_e = 1'b1;
      frame("left_sat", 1'b1, 332, 0, 1'b0);
      frame("left_hold0", 1'b1, 332, 0, 1'b0);

      btn_left_e = 1'b0;
      btn_right  = 1'b1;
      for (int i = 1; i <= 76; i++) frame("walk", 1'b1, 332 + 4 * i, 0, 1'b0);
      frame("right_sat", 1'b1, 639, 0, 1'b0);
      frame("right_hold", 1'b1, 639, 0, 1'b0);

      btn_left = 1'b1;
      frame("both", 1'b1, 639, 0, 1'b0);

      btn_left  = 1'b0;
      btn_right = 1'b0;
      enable    = 1'b0;
      frame("disabled", 1'b0, 639, 0, 1'b0);

      enable   = 1'b1;
      btn_left = 1'b1;
      repeat (3) @(negedge clk_in);
      frame("en_drop", 1'b0, 639, 0, 1'b1);
      enable = 1'b1;
      repeat (3) @(negedge clk_in);
      frame("left_after", 1'b1, 635, 0, 1'b0);

      @(negedge clk_in);
      tick_in = 1'b1;
      repeat (4) @(negedge clk_in);
      check("mid.state", 32'(dut.state), 32'(S_MOVE));
      reset = 1'b0;
      #1;
      check("mid.pos", 32'(pos), 32'd320);
      check("mid.pv", 32'(pos_valid), 32'd0);
      check("mid.state_idle", 32'(dut.state), 32'(S_IDLE));
      check("mid.edge", 32'(at_edge), 32'd0);
      check("mid.pos_e", 32'(pos_e), 32'd2);
      tick_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("mid.hold_pos", 32'(pos), 32'd320);
      reset     = 1'b1;
      btn_left  = 1'b0;
      btn_right = 1'b1;
      repeat (3) @(negedge clk_in);
      frame("post_rst", 1'b1, 324, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
